uart_block_sender: RTL and testbench

//  Upstream feeder for the UART transmitter. Accepts one AES-128 block (ciphertext) on a valid/ready

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_block_sender.sv | 168 ++++++++++++++++
 tb/tb_uart_block_sender.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, the block sender and the receiver.
package uart_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int AES_BLOCK_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } sender_state_e;

endpackage

// File: rtl/uart_block_sender.sv
// Serialises one accepted cipher block into bytes for the UART transmitter, one tx_drive
// strobe per byte, pacing on tx_done and abandoning the block if the line stalls.
module uart_block_sender
    import uart_pkg::*;
#(
    parameter int NUM_BYTES    = 16,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int TIMEOUT_CLKS = 8192
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            blk_valid,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0] blk_data,
    output logic                            blk_ready,
    output logic                            tx_drive,
    output logic [DATA_WIDTH-1:0]           tx_byte_in,
    input  logic                            tx_active,
    input  logic                            tx_done,
    output logic                            busy,
    output logic                            blk_sent,
    output logic                            err_timeout
);

    localparam int BLOCK_WIDTH = DATA_WIDTH * NUM_BYTES;
    localparam int CNT_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WDOG_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CLKS - 1);

    sender_state_e           r_state;
    sender_state_e           w_state_nxt;
    logic [BLOCK_WIDTH-1:0]  r_shreg;
    logic [BLOCK_WIDTH-1:0]  w_shreg_nxt;
    logic [BLOCK_WIDTH-1:0]  w_shreg_shifted;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [CNT_W-1:0]        w_byte_cnt_nxt;
    logic [WDOG_W-1:0]       r_wdog;
    logic [WDOG_W-1:0]       w_wdog_nxt;
    logic [DATA_WIDTH-1:0]   w_cur_byte;
    logic                    w_accept;
    logic                    w_last_byte;
    logic                    w_expired;

    logic                    r_blk_ready,   w_blk_ready_nxt;
    logic                    r_tx_drive,    w_tx_drive_nxt;
    logic [DATA_WIDTH-1:0]   r_tx_byte,     w_tx_byte_nxt;
    logic                    r_busy,        w_busy_nxt;
    logic                    r_blk_sent,    w_blk_sent_nxt;
    logic                    r_err_timeout, w_err_timeout_nxt;

    // The shift register always presents the next byte to send at the same end.
    assign w_cur_byte      = MSB_FIRST ? r_shreg[BLOCK_WIDTH-1 -: DATA_WIDTH] : r_shreg[DATA_WIDTH-1:0];
    assign w_shreg_shifted = MSB_FIRST ? (r_shreg << DATA_WIDTH) : (r_shreg >> DATA_WIDTH);

    assign w_accept    = blk_valid && r_blk_ready;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_expired   = (r_wdog == WDOG_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_byte_cnt    <= '0;
            r_wdog        <= '0;
            r_blk_ready   <= 1'b1;
            r_tx_drive    <= 1'b0;
            r_tx_byte     <= '0;
            r_busy        <= 1'b0;
            r_blk_sent    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shreg       <= w_shreg_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_wdog        <= w_wdog_nxt;
            r_blk_ready   <= w_blk_ready_nxt;
            r_tx_drive    <= w_tx_drive_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_busy        <= w_busy_nxt;
            r_blk_sent    <= w_blk_sent_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done)        w_state_nxt = w_last_byte ? IDLE : ISSUE;
                else if (w_expired) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_shreg_nxt       = r_shreg;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_wdog_nxt        = r_wdog;
        w_blk_ready_nxt   = r_blk_ready;
        w_tx_drive_nxt    = 1'b0;
        w_tx_byte_nxt     = r_tx_byte;
        w_busy_nxt        = r_busy;
        w_blk_sent_nxt    = 1'b0;
        w_err_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt     = blk_data;
                    w_byte_cnt_nxt  = '0;
                    w_busy_nxt      = 1'b1;
                    w_blk_ready_nxt = 1'b0;
                end
            end
            ISSUE: begin
                w_tx_drive_nxt = 1'b1;
                w_tx_byte_nxt  = w_cur_byte;
                w_shreg_nxt    = w_shreg_shifted;
                w_wdog_nxt     = '0;
            end
            WAIT_DONE: begin
                // A completion in the expiry cycle still counts as a delivered byte.
                if (tx_done) begin
                    if (w_last_byte) begin
                        w_blk_sent_nxt  = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_blk_ready_nxt = 1'b1;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    end
                end else if (w_expired) begin
                    w_err_timeout_nxt = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_blk_ready_nxt   = 1'b1;
                end else if (!tx_active) begin
                    w_wdog_nxt = r_wdog + WDOG_W'(1);
                end
            end
            default: begin
                w_shreg_nxt       = 'x;
                w_byte_cnt_nxt    = 'x;
                w_wdog_nxt        = 'x;
                w_blk_ready_nxt   = 'x;
                w_tx_drive_nxt    = 'x;
                w_tx_byte_nxt     = 'x;
                w_busy_nxt        = 'x;
                w_blk_sent_nxt    = 'x;
                w_err_timeout_nxt = 'x;
            end
        endcase
    end

    assign blk_ready   = r_blk_ready;
    assign tx_drive    = r_tx_drive;
    assign tx_byte_in  = r_tx_byte;
    assign busy        = r_busy;
    assign blk_sent    = r_blk_sent;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_block_sender.sv
// Randomised bench for uart_block_sender: a byte-queue reference model checked every cycle,
// a behavioural transmitter stand-in, and directed scenarios with hand-computed expectations.
module tb_uart_block_sender;

    localparam int NB = 16;
    localparam int TO = 64;
    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hA5C3_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2;

    logic         clk;
    logic         reset;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         tx_drive;
    logic [7:0]   tx_byte_in;
    logic         tx_active;
    logic         tx_done;
    logic         busy;
    logic         blk_sent;
    logic         err_timeout;

    logic         l_valid;
    logic [127:0] l_data;
    logic         l_ready;
    logic         l_drive;
    logic [7:0]   l_byte;
    logic         l_active;
    logic         l_done;
    logic         l_busy;
    logic         l_sent;
    logic         l_to;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_on  = 0;
    int  rmode   = 0;

    // reference model state
    logic [7:0] m_q[$];
    bit         m_busy;
    bit         m_due;
    bit         m_wait;
    int         m_waited;
    bit         e_drive;
    bit         e_sent;
    bit         e_to;
    logic [7:0] e_byte;

    // observation
    logic [7:0] cap[$];
    int   drv_cnt = 0, sent_cnt = 0, to_cnt = 0, dn_cnt = 0, max_gap = 0;
    time  last_done_t = 0, last_drv_t = 0, last_sent_t = 0, last_to_t = 0, last_rise_t = 0;
    bit   prev_busy = 0;

    uart_block_sender #(.NUM_BYTES(NB), .MSB_FIRST(1'b1), .TIMEOUT_CLKS(TO)) u_dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready), .tx_drive(tx_drive), .tx_byte_in(tx_byte_in),
        .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
        .blk_sent(blk_sent), .err_timeout(err_timeout)
    );

    uart_block_sender #(.NUM_BYTES(NB), .MSB_FIRST(1'b0), .TIMEOUT_CLKS(TO)) u_lsb (
        .clk(clk), .reset(reset), .blk_valid(l_valid), .blk_data(l_data),
        .blk_ready(l_ready), .tx_drive(l_drive), .tx_byte_in(l_byte),
        .tx_active(l_active), .tx_done(l_done), .busy(l_busy),
        .blk_sent(l_sent), .err_timeout(l_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a block becomes a byte queue; each rule below is a sentence of the behaviour.
    initial begin
        m_busy = 0; m_due = 0; m_wait = 0; m_waited = 0;
        e_drive = 0; e_sent = 0; e_to = 0; e_byte = 8'h00;
        forever begin
            @(posedge clk);
            e_drive = 0; e_sent = 0; e_to = 0;
            if (tx_done === 1'b1 && !reset) begin
                dn_cnt++;
                last_done_t = $time;
            end
            if (reset) begin
                m_busy = 0; m_due = 0; m_wait = 0; m_waited = 0;
                m_q.delete();
                e_byte = 8'h00;
            end else if (!m_busy) begin
                if (blk_valid) begin
                    for (int i = 0; i < NB; i++) m_q.push_back(blk_data[8*(NB-1-i) +: 8]);
                    m_busy = 1;
                    m_due  = 1;
                end
            end else if (m_due) begin
                e_drive  = 1;
                e_byte   = m_q.pop_front();
                m_due    = 0;
                m_wait   = 1;
                m_waited = 0;
            end else if (m_wait) begin
                if (tx_done) begin
                    m_wait = 0;
                    if (m_q.size() == 0) begin
                        m_busy = 0;
                        e_sent = 1;
                    end else begin
                        m_due = 1;
                    end
                end else if (m_waited == TO - 1) begin
                    m_wait = 0;
                    m_busy = 0;
                    e_to   = 1;
                    m_q.delete();
                end else if (!tx_active) begin
                    m_waited++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on)
                check($sformatf("outputs@%0t {ready,drive,busy,sent,to,byte}", $time),
                      {blk_ready, tx_drive, busy, blk_sent, err_timeout, tx_byte_in},
                      {~m_busy, e_drive, m_busy, e_sent, e_to, e_byte});
        end
    end

    // Observation of strobes, pulses and their times.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_drive === 1'b1) begin
                cap.push_back(tx_byte_in);
                drv_cnt++;
                if (last_done_t != 0 && int'(($time - last_done_t - 5) / 10) > max_gap)
                    max_gap = int'(($time - last_done_t - 5) / 10);
                last_drv_t = $time;
            end
            if (blk_sent === 1'b1) begin
                sent_cnt++;
                last_sent_t = $time;
            end
            if (err_timeout === 1'b1) begin
                to_cnt++;
                last_to_t = $time;
            end
            if (busy === 1'b1 && !prev_busy) last_rise_t = $time;
            prev_busy = (busy === 1'b1);
        end
    end

    // Transmitter stand-in: answers each strobe with tx_done after a mode-dependent delay.
    initial begin
        int rcnt;
        int pick;
        rcnt = 0;
        tx_done = 1'b0;
        tx_active = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset) begin
                tx_active = 1'b0;
                rcnt = 0;
            end else if (tx_drive === 1'b1) begin
                pick = $urandom_range(0, 99);
                if (rmode == 1) begin
                    rcnt = 0; tx_active = 1'b0;
                end else if (rmode == 0 || pick < 50) begin
                    rcnt = $urandom_range(1, 8); tx_active = 1'b1;
                end else if (pick < 62) begin
                    rcnt = $urandom_range(65, 100); tx_active = 1'b1;
                end else if (pick < 88) begin
                    rcnt = $urandom_range(1, 62); tx_active = 1'b0;
                end else if (pick < 94) begin
                    rcnt = TO - 1; tx_active = 1'b0;
                end else if (pick < 97) begin
                    rcnt = TO; tx_active = 1'b0;
                end else begin
                    rcnt = 0; tx_active = 1'b0;
                end
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    tx_done = 1'b1;
                    tx_active = 1'b0;
                end
            end else if (rmode == 2 && busy === 1'b0 && $urandom_range(0, 9) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    task automatic send_block(input logic [127:0] d, input bit hold);
        int k;
        blk_data  = d;
        blk_valid = 1'b1;
        for (k = 0; k < 200 && blk_ready !== 1'b1; k++) @(negedge clk);
        check("accept_ready", blk_ready, 1'b1);
        @(negedge clk);
        if (!hold) begin
            blk_valid = 1'b0;
            blk_data  = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_for_end(input int base, input int maxc, input bit poke);
        int k;
        for (k = 0; k < maxc && (sent_cnt + to_cnt) <= base; k++) begin
            @(negedge clk);
            if (poke) begin
                blk_valid = (busy === 1'b1) && ($urandom_range(0, 3) == 0);
                blk_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (poke) blk_valid = 1'b0;
        check("block_end_within_bound", ((sent_cnt + to_cnt) > base), 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int s0, t0, d0, k, base, ldly, lsent;
        time t_s1, t_rise;
        logic [127:0] va, vb;
        logic [7:0]   lcap[$];
        va = BLK_A;
        vb = BLK_B;
        reset = 1'b1; blk_valid = 1'b0; blk_data = '0;
        l_valid = 1'b0; l_data = '0; l_active = 1'b0; l_done = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("reset_values", {blk_ready, tx_drive, busy, blk_sent, err_timeout, tx_byte_in},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        check("reset_values_lsb", {l_ready, l_drive, l_busy, l_sent, l_to, l_byte},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        chk_on = 1;
        @(negedge clk);

        // one block, MSB first
        rmode = 0; cap.delete(); s0 = sent_cnt; base = sent_cnt + to_cnt;
        send_block(BLK_A, 0);
        wait_for_end(base, 2000, 0);
        check("t2_byte_count", cap.size(), 16);
        check("t2_first_byte", cap[0], 8'h00);
        check("t2_second_byte", cap[1], 8'h11);
        check("t2_last_byte", cap[15], 8'hFF);
        check("t2_sent_once", sent_cnt - s0, 1);
        check("t2_busy_after", busy, 1'b0);

        // LSB-first instance
        l_data = BLK_A; l_valid = 1'b1;
        @(negedge clk);
        l_valid = 1'b0; l_data = '0;
        ldly = 0; lsent = 0;
        for (int c = 0; c < 600 && lsent == 0; c++) begin
            @(negedge clk);
            l_done = 1'b0;
            if (l_sent === 1'b1) lsent++;
            if (l_drive === 1'b1) begin
                lcap.push_back(l_byte);
                ldly = 3;
            end else if (ldly > 0) begin
                ldly--;
                if (ldly == 0) l_done = 1'b1;
            end
        end
        check("t3_byte_count", lcap.size(), 16);
        check("t3_first_byte", lcap[0], 8'hFF);
        check("t3_last_byte", lcap[15], 8'h00);
        k = 0;
        for (int i = 0; i < lcap.size() && i < 16; i++) if (lcap[i] !== va[8*i +: 8]) k++;
        check("t3_byte_order_errors", k, 0);
        check("t3_sent_once", lsent, 1);

        // back-to-back blocks with valid held
        rmode = 0; cap.delete(); s0 = sent_cnt; d0 = drv_cnt; max_gap = 0; last_done_t = 0;
        send_block(BLK_A, 1);
        blk_data = BLK_B;
        for (k = 0; k < 3000 && !((sent_cnt - s0) >= 1 && busy === 1'b1); k++) @(negedge clk);
        blk_valid = 1'b0;
        @(negedge clk);
        t_s1 = last_sent_t; t_rise = last_rise_t;
        check("t4_accept_after_sent", t_rise - t_s1, 10);
        wait_for_end(sent_cnt + to_cnt, 3000, 0);
        check("t4_total_bytes", drv_cnt - d0, 32);
        check("t4_sent_twice", sent_cnt - s0, 2);
        check("t4_max_gap", max_gap, 2);
        check("t4_block1_last", cap[15], 8'hFF);
        check("t4_block2_first", cap[16], vb[127:120]);

        // stalled transmitter
        rmode = 1; s0 = sent_cnt; d0 = drv_cnt; t0 = to_cnt;
        send_block(BLK_B, 0);
        wait_for_end(sent_cnt + to_cnt, 300, 0);
        check("t5_timeout_latency", (last_to_t - last_drv_t) / 10, 64);
        check("t5_ready_after_timeout", blk_ready, 1'b1);
        check("t5_single_strobe", drv_cnt - d0, 1);
        repeat (5) @(negedge clk);
        check("t5_timeout_once", to_cnt - t0, 1);
        check("t5_no_sent", sent_cnt - s0, 0);

        // reset in the middle of a block
        rmode = 0; cap.delete(); s0 = sent_cnt; d0 = dn_cnt;
        send_block(BLK_B, 0);
        for (k = 0; k < 2000 && (dn_cnt - d0) < 6; k++) @(negedge clk);
        check("t6_reached_byte5_done", dn_cnt - d0, 6);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", {blk_ready, tx_drive, busy, blk_sent, err_timeout, tx_byte_in},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_bytes_before_reset", cap.size(), 6);
        check("t6_no_sent_for_abandoned", sent_cnt - s0, 0);
        send_block(BLK_A, 0);
        wait_for_end(sent_cnt + to_cnt, 2000, 0);
        check("t6_restart_first_byte", cap[6], 8'h00);
        check("t6_restart_byte_count", cap.size(), 22);
        check("t6_restart_sent", sent_cnt - s0, 1);

        // randomised traffic
        rmode = 2;
        for (int b = 0; b < 40; b++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            base = sent_cnt + to_cnt;
            send_block({$urandom, $urandom, $urandom, $urandom}, 0);
            wait_for_end(base, 6000, 1);
        end
        rmode = 0;
        repeat (120) @(negedge clk);
        check("rand_idle_at_end", {blk_ready, busy}, 2'b10);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
